inj_pulse_sched: RTL



---
 rtl/inj_pulse_sched_pkg.sv | 14 +
 rtl/inj_pulse_sched_if.sv | 28 ++
 rtl/inj_pulse_sched_sat_down_counter.sv | 30 +++
 rtl/inj_pulse_sched.sv | 84 ++++++++
 4 files changed

// File: rtl/inj_pulse_sched_pkg.sv
// Shared engine-control constants: FSM state encoding and crank/time scaling.
package efi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t OPEN = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int QUANTA_PER_TOOTH = 256;
  localparam int TOOTH_SHIFT      = 8;
  localparam int TICKS_PER_MS     = 2000;

endpackage

// File: rtl/inj_pulse_sched_if.sv
// Channel bus between the crank synchronizer/config side and one injector scheduler.
interface inj_pulse_sched_if #(
  parameter int PHASE_W = 16,
  parameter int PW_W    = 32,
  parameter int DT_W    = 16,
  parameter int OVL_W   = 8
);
  logic               en;
  logic               trigger;
  logic [PHASE_W-1:0] eng_phase;
  logic [PHASE_W-1:0] start_phase;
  logic [PW_W-1:0]    pw;
  logic [DT_W-1:0]    dead_time;
  logic               inj_out;
  logic               busy;
  logic               pulse_done;
  logic [OVL_W-1:0]   overlap_cnt;

  modport master (
    output en, trigger, eng_phase, start_phase, pw, dead_time,
    input  inj_out, busy, pulse_done, overlap_cnt
  );

  modport slave (
    input  en, trigger, eng_phase, start_phase, pw, dead_time,
    output inj_out, busy, pulse_done, overlap_cnt
  );
endinterface

// File: rtl/inj_pulse_sched_sat_down_counter.sv
// Loadable down-counter that stops at zero; tc flags the final counted cycle (count==1).
module sat_down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (load)                 cnt_d = load_val;
    else if (dec && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/inj_pulse_sched.sv
// Per-channel injector pulse scheduler: opens on the matching crank tooth for pw+dead_time ticks.
// Build option INJ_SCHED_MIN_PW_EN suppresses pulses shorter than MIN_PW ticks.
module inj_pulse_sched
  import efi_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int PW_W    = 32,
  parameter int DT_W    = 16,
  parameter int OVL_W   = 8,
  parameter int MIN_PW  = 200
) (
  input  logic             clk,
  input  logic             reset,
  inj_pulse_sched_if.slave bus
);

`ifdef INJ_SCHED_MIN_PW_EN
  localparam bit MIN_PW_EN = 1'b1;
`else
  localparam bit MIN_PW_EN = 1'b0;
`endif
  // Without the minimum-pulse option any non-zero length is issued.
  localparam logic [PW_W-1:0] MIN_LEN = MIN_PW_EN ? PW_W'(MIN_PW) : PW_W'(1);

  state_t           state_q, state_d;
  logic [OVL_W-1:0] ovl_q, ovl_d;
  logic [PW_W:0]    len_sum;
  logic [PW_W-1:0]  len;
  logic             match, start, cnt_tc;
  logic             cnt_load, cnt_dec, cnt_clr;

  // Tooth-granular compare: sub-tooth quanta of both phases are ignored.
  assign match   = bus.trigger &&
                   (bus.eng_phase[PHASE_W-1:TOOTH_SHIFT] == bus.start_phase[PHASE_W-1:TOOTH_SHIFT]);
  assign len_sum = {1'b0, bus.pw} + {{(PW_W+1-DT_W){1'b0}}, bus.dead_time};
  assign len     = len_sum[PW_W] ? '1 : len_sum[PW_W-1:0];
  assign start   = match && bus.en && (len >= MIN_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ovl_q   <= '0;
    end else begin
      state_q <= state_d;
      ovl_q   <= ovl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? OPEN : IDLE;
      OPEN: begin
        if (!bus.en)     state_d = IDLE;
        else if (cnt_tc) state_d = DONE;
      end
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.inj_out    = (state_q == OPEN);
    bus.busy       = (state_q == OPEN);
    bus.pulse_done = (state_q == OPEN) && bus.en && cnt_tc;
    cnt_load       = (state_q != OPEN) && start;
    cnt_dec        = (state_q == OPEN) && bus.en;
    cnt_clr        = (state_q == OPEN) && !bus.en;
    ovl_d          = ovl_q;
    if ((state_q == OPEN) && match && (ovl_q != '1)) ovl_d = ovl_q + 1'b1;
  end

  assign bus.overlap_cnt = ovl_q;

  sat_down_counter #(.W(PW_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (len),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

endmodule
